// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [3:0] PC_REG      = 4'hF;
   localparam logic [3:0] MEM_TIMEOUT = 4'd15;

   // Saturating 16-bit increment for the event counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Execute operand forwarding select; Memory stage wins over Writeback, PC never forwarded.
module fwd_select
   import hazard_pkg::*;
(
   input  logic [3:0] ra_e,
   input  logic [3:0] wa3_m,
   input  logic       reg_write_m,
   input  logic [3:0] wa3_w,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (ra_e != PC_REG) begin
         if (reg_write_m && (wa3_m == ra_e))
            fwd = FWD_M;
         else if (reg_write_w && (wa3_w == ra_e))
            fwd = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch/memory-wait stalls and flushes,
// memory timeout watchdog and saturating stall/flush event counters.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  RA1D,
   input  logic [3:0]  RA2D,
   input  logic [3:0]  RA1E,
   input  logic [3:0]  RA2E,
   input  logic [3:0]  WA3E,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        BranchTakenE,
   input  logic [3:0]  WA3M,
   input  logic [3:0]  RA2M,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic        MemReadyM,
   input  logic [3:0]  WA3W,
   input  logic        RegWriteW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        ForwardM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        MemTimeout,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount
);

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic        mem_busy;
   logic        ld_use;
   logic        branch_flush;
   logic [1:0]  fwd_a, fwd_b;

   assign mem_busy = (MemWriteM || MemtoRegM) && !MemReadyM;
   assign ld_use   = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));

   fwd_select u_fwd_a (
      .ra_e        (RA1E),
      .wa3_m       (WA3M),
      .reg_write_m (RegWriteM),
      .wa3_w       (WA3W),
      .reg_write_w (RegWriteW),
      .fwd         (fwd_a)
   );

   fwd_select u_fwd_b (
      .ra_e        (RA2E),
      .wa3_m       (WA3M),
      .reg_write_m (RegWriteM),
      .wa3_w       (WA3W),
      .reg_write_w (RegWriteW),
      .fwd         (fwd_b)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Wait counter holds at its top value so the timeout condition stays visible.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      case (state_q)
         RUN: begin
            if (mem_busy)
               state_d = MEMWAIT;
         end
         MEMWAIT: begin
            if (MemReadyM)
               state_d = RUN;
            wait_cnt_d = (wait_cnt_q == MEM_TIMEOUT) ? wait_cnt_q : wait_cnt_q + 4'd1;
            if ((wait_cnt_q == MEM_TIMEOUT) && !MemReadyM)
               timeout_d = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      StallF       = 1'b0;
      StallD       = 1'b0;
      StallE       = 1'b0;
      StallM       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      branch_flush = 1'b0;
      if (RESET) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (mem_busy) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (BranchTakenE) begin
         FlushD       = 1'b1;
         FlushE       = 1'b1;
         branch_flush = 1'b1;
      end else if (ld_use) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = sat_inc(stall_cnt_q, StallF);
      flush_cnt_d = sat_inc(flush_cnt_q, branch_flush);
   end

   assign ForwardAE  = RESET ? FWD_RF : fwd_a;
   assign ForwardBE  = RESET ? FWD_RF : fwd_b;
   assign ForwardM   = !RESET && MemWriteM && RegWriteW && (WA3W == RA2M) && (RA2M != PC_REG);
   assign MemTimeout = timeout_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle memory-wait/reset sequences.
module tb_hazard_ctrl;

   logic        CLK, RESET;
   logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W;
   logic        RegWriteE, MemtoRegE, BranchTakenE;
   logic        RegWriteM, MemWriteM, MemtoRegM, MemReadyM, RegWriteW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        ForwardM, StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
   logic [15:0] StallCount, FlushCount;

   hazard_ctrl dut (
      .CLK(CLK), .RESET(RESET),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
      .WA3M(WA3M), .RA2M(RA2M),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .MemReadyM(MemReadyM),
      .WA3W(WA3W), .RegWriteW(RegWriteW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .MemTimeout(MemTimeout),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e;
      logic       regwe, memtorege, brt;
      logic [3:0] wa3m, ra2m;
      logic       regwm, memwm, memtoregm, memrdy;
      logic [3:0] wa3w;
      logic       regww;
      logic [1:0] fae, fbe;
      logic       fm;
      logic [3:0] stall;   // {F, D, E, M}
      logic [1:0] flush;   // {D, E}
   } vec_t;

   typedef struct {
      int          id;
      logic [1:0]  fae, fbe;
      logic        fm;
      logic [3:0]  stall;
      logic [1:0]  flush;
      logic        to;
      logic [15:0] scnt, fcnt;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[$];
   int          errors = 0;
   int          checks = 0;
   int          id_ctr = 0;
   logic [15:0] exp_scnt = '0;
   logic [15:0] exp_fcnt = '0;

   task automatic chk(input string n, input int id, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h want %h", n, id, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("ForwardAE",  e.id, {14'd0, ForwardAE}, {14'd0, e.fae});
         chk("ForwardBE",  e.id, {14'd0, ForwardBE}, {14'd0, e.fbe});
         chk("ForwardM",   e.id, {15'd0, ForwardM}, {15'd0, e.fm});
         chk("Stall",      e.id, {12'd0, StallF, StallD, StallE, StallM}, {12'd0, e.stall});
         chk("Flush",      e.id, {14'd0, FlushD, FlushE}, {14'd0, e.flush});
         chk("MemTimeout", e.id, {15'd0, MemTimeout}, {15'd0, e.to});
         chk("StallCount", e.id, StallCount, e.scnt);
         chk("FlushCount", e.id, FlushCount, e.fcnt);
      end
   end

   task automatic drive(input vec_t v, input logic rst, input logic exp_to);
      exp_t e;
      @(posedge CLK);
      #1;
      RESET = rst;
      RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e; WA3E = v.wa3e;
      RegWriteE = v.regwe; MemtoRegE = v.memtorege; BranchTakenE = v.brt;
      WA3M = v.wa3m; RA2M = v.ra2m; RegWriteM = v.regwm; MemWriteM = v.memwm;
      MemtoRegM = v.memtoregm; MemReadyM = v.memrdy; WA3W = v.wa3w; RegWriteW = v.regww;
      e.id = id_ctr;
      id_ctr++;
      if (rst) begin
         exp_scnt = '0;
         exp_fcnt = '0;
         e.fae = 2'b00; e.fbe = 2'b00; e.fm = 1'b0;
         e.stall = 4'b0000; e.flush = 2'b11; e.to = 1'b0;
         e.scnt = '0; e.fcnt = '0;
      end else begin
         e.fae = v.fae; e.fbe = v.fbe; e.fm = v.fm;
         e.stall = v.stall; e.flush = v.flush; e.to = exp_to;
         e.scnt = exp_scnt; e.fcnt = exp_fcnt;
         if (v.stall[3] && exp_scnt != 16'hFFFF) exp_scnt = exp_scnt + 16'd1;
         if (v.brt && v.flush[0] && exp_fcnt != 16'hFFFF) exp_fcnt = exp_fcnt + 16'd1;
      end
      sb.push_back(e);
   endtask

   vec_t v, idle, busy, rdy, fwdv;

   initial begin
      RESET = 1'b1;
      {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W} = '0;
      {RegWriteE, MemtoRegE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM, MemReadyM, RegWriteW} = '0;

      idle = '0;
      busy = '0; busy.memtoregm = 1'b1; busy.stall = 4'b1111;
      rdy  = '0; rdy.memtoregm = 1'b1; rdy.memrdy = 1'b1;

      // 0: quiet
      v = '0; tbl.push_back(v);
      // 1-3: Memory beats Writeback; PC source never forwarded
      v = '0; v.ra1e = 3; v.wa3m = 3; v.regwm = 1; v.wa3w = 3; v.regww = 1; v.fae = 2'b10; tbl.push_back(v);
      v = '0; v.ra1e = 3; v.wa3m = 3; v.regwm = 0; v.wa3w = 3; v.regww = 1; v.fae = 2'b01; tbl.push_back(v);
      v = '0; v.ra1e = 15; v.wa3m = 15; v.regwm = 1; v.wa3w = 15; v.regww = 1; tbl.push_back(v);
      // 4-5: operand B paths
      v = '0; v.ra2e = 7; v.wa3m = 7; v.wa3w = 7; v.regww = 1; v.fbe = 2'b01; tbl.push_back(v);
      v = '0; v.ra1e = 2; v.ra2e = 2; v.wa3m = 2; v.regwm = 1; v.fae = 2'b10; v.fbe = 2'b10; tbl.push_back(v);
      // 6-8: store-data forwarding
      v = '0; v.memwm = 1; v.memrdy = 1; v.ra2m = 6; v.wa3w = 6; v.regww = 1; v.fm = 1; tbl.push_back(v);
      v = '0; v.memwm = 1; v.memrdy = 1; v.ra2m = 15; v.wa3w = 15; v.regww = 1; tbl.push_back(v);
      v = '0; v.ra2m = 6; v.wa3w = 6; v.regww = 1; tbl.push_back(v);
      // 9-10: load-use on RA2D, and non-hazard when RegWriteE low
      v = '0; v.memtorege = 1; v.regwe = 1; v.wa3e = 5; v.ra2d = 5; v.stall = 4'b1100; v.flush = 2'b01; tbl.push_back(v);
      v = '0; v.memtorege = 1; v.regwe = 0; v.wa3e = 5; v.ra2d = 5; tbl.push_back(v);
      // 11-12: branch alone, branch over load-use
      v = '0; v.brt = 1; v.flush = 2'b11; tbl.push_back(v);
      v = '0; v.brt = 1; v.memtorege = 1; v.regwe = 1; v.wa3e = 5; v.ra2d = 5; v.flush = 2'b11; tbl.push_back(v);
      // 13-14: memory busy overrides branch and load-use, then ready
      v = busy; v.brt = 1; v.memtorege = 1; v.regwe = 1; v.wa3e = 5; v.ra2d = 5; tbl.push_back(v);
      v = rdy; tbl.push_back(v);
      // 15-16: load-use on RA1D; PC on operand B
      v = '0; v.memtorege = 1; v.regwe = 1; v.wa3e = 9; v.ra1d = 9; v.stall = 4'b1100; v.flush = 2'b01; tbl.push_back(v);
      v = '0; v.ra2e = 15; v.wa3m = 15; v.regwm = 1; tbl.push_back(v);

      drive(idle, 1'b1, 1'b0);
      drive(idle, 1'b1, 1'b0);
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i], 1'b0, 1'b0);

      // Short memory wait: three busy cycles, then ready
      for (int k = 0; k < 3; k++) drive(busy, 1'b0, 1'b0);
      drive(rdy, 1'b0, 1'b0);
      drive(idle, 1'b0, 1'b0);

      // Long wait: timeout visible once the counter has sat at 15 with ready low
      for (int k = 0; k < 20; k++) drive(busy, 1'b0, (k >= 17));
      drive(rdy, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) drive(idle, 1'b0, 1'b1);

      // Reset in the middle of a new wait, with forwarding inputs active
      for (int k = 0; k < 5; k++) drive(busy, 1'b0, 1'b1);
      fwdv = busy; fwdv.ra1e = 3; fwdv.wa3m = 3; fwdv.regwm = 1; fwdv.memwm = 1;
      fwdv.ra2m = 6; fwdv.wa3w = 6; fwdv.regww = 1; fwdv.brt = 1;
      drive(fwdv, 1'b1, 1'b0);
      drive(fwdv, 1'b1, 1'b0);

      // After reset the FSM must be in RUN: idle with ready low must never time out
      for (int k = 0; k < 18; k++) drive(idle, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) drive(busy, 1'b0, 1'b0);
      drive(rdy, 1'b0, 1'b0);
      v = '0; v.brt = 1; v.flush = 2'b11;
      drive(v, 1'b0, 1'b0);
      drive(idle, 1'b0, 1'b0);

      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
